axi_read_arbiter: RTL and testbench



---
 rtl/axi_read_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares the single AXI4 read channel (AR/R) between the
// icache and the dcache. One burst in flight at a time, round-robin on ties.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ic_req_* / dc_req_*        burst requests (valid, addr, len) and AR-accept pulse (ready)
//   ic_r* / dc_r*              R beats steered to the owning cache
//   m_axi_ar*                  registered AR channel towards the bus
//   m_axi_r*                   R channel from the bus (always accepted in DATA)
//   busy                       arbiter is not idle
//   rid_err                    one-cycle pulse after a beat with an unexpected RID
module axi_read_arbiter #(
    parameter int unsigned         ID_WIDTH   = 13,
    parameter int unsigned         ADDR_WIDTH = 64,
    parameter int unsigned         DATA_WIDTH = 64,
    parameter logic [ID_WIDTH-1:0] IC_ID      = '0,
    parameter logic [ID_WIDTH-1:0] DC_ID      = ID_WIDTH'(1)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    input  logic [7:0]            ic_req_len,
    output logic                  ic_req_ready,
    output logic                  ic_rvalid,
    output logic                  ic_rlast,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    output logic [1:0]            ic_rresp,

    input  logic                  dc_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [7:0]            dc_req_len,
    output logic                  dc_req_ready,
    output logic                  dc_rvalid,
    output logic                  dc_rlast,
    output logic [DATA_WIDTH-1:0] dc_rdata,
    output logic [1:0]            dc_rresp,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  busy,
    output logic                  rid_err
);

    localparam int unsigned LEN_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  owner_q;       // 0 = icache, 1 = dcache
    logic                  last_grant_q;  // owner of the most recent grant
    logic                  rid_err_q;
    logic [ID_WIDTH-1:0]   ar_id_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [LEN_WIDTH-1:0]  ar_len_q;

    logic any_req_c;
    logic win_dc_c;
    logic ar_hs_c;
    logic beat_c;
    logic beat_ok_c;
    logic beat_bad_c;

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    assign any_req_c  = ic_req_valid | dc_req_valid;
    assign win_dc_c   = dc_req_valid & (~ic_req_valid | ~last_grant_q);

    assign ar_hs_c    = (state_q == ADDR) & m_axi_arready;
    assign beat_c     = (state_q == DATA) & m_axi_rvalid;
    assign beat_ok_c  = beat_c & (m_axi_rid == ar_id_q);
    assign beat_bad_c = beat_c & (m_axi_rid != ar_id_q);

    // Next-state logic; only a matching-ID last beat closes the burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c)              state_d = ADDR;
            ADDR:    if (m_axi_arready)          state_d = DATA;
            DATA:    if (beat_ok_c && m_axi_rlast) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping and AR registers, latched only at grant time.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rid_err_q    <= 1'b0;
            ar_id_q      <= '0;
            ar_addr_q    <= '0;
            ar_len_q     <= '0;
        end else begin
            rid_err_q <= beat_bad_c;
            if (state_q == IDLE && any_req_c) begin
                owner_q      <= win_dc_c;
                last_grant_q <= win_dc_c;
                ar_id_q      <= win_dc_c ? DC_ID : IC_ID;
                ar_addr_q    <= win_dc_c ? dc_req_addr : ic_req_addr;
                ar_len_q     <= win_dc_c ? dc_req_len : ic_req_len;
            end
        end
    end

    assign m_axi_arid    = ar_id_q;
    assign m_axi_araddr  = ar_addr_q;
    assign m_axi_arlen   = ar_len_q;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b10;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == ADDR);
    assign m_axi_rready  = (state_q == DATA);

    assign busy    = (state_q != IDLE);
    assign rid_err = rid_err_q;

    // Accept pulse and beat steering go only to the current owner.
    assign ic_req_ready = ar_hs_c & ~owner_q;
    assign dc_req_ready = ar_hs_c & owner_q;

    assign ic_rvalid = beat_ok_c & ~owner_q;
    assign ic_rlast  = ic_rvalid & m_axi_rlast;
    assign ic_rdata  = ic_rvalid ? m_axi_rdata : '0;
    assign ic_rresp  = ic_rvalid ? m_axi_rresp : 2'b00;

    assign dc_rvalid = beat_ok_c & owner_q;
    assign dc_rlast  = dc_rvalid & m_axi_rlast;
    assign dc_rdata  = dc_rvalid ? m_axi_rdata : '0;
    assign dc_rresp  = dc_rvalid ? m_axi_rresp : 2'b00;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed scenarios plus a randomized soak, all
// compared cycle by cycle against a transaction-level reference model.
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req_valid, dc_req_valid;
    logic [63:0] ic_req_addr, dc_req_addr;
    logic [7:0]  ic_req_len, dc_req_len;
    logic        ic_req_ready, dc_req_ready;
    logic        ic_rvalid, dc_rvalid, ic_rlast, dc_rlast;
    logic [63:0] ic_rdata, dc_rdata;
    logic [1:0]  ic_rresp, dc_rresp;
    logic [12:0] m_axi_arid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid, m_axi_arready;
    logic [12:0] m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        busy, rid_err;

    axi_read_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_len(ic_req_len),
        .ic_req_ready(ic_req_ready), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
        .ic_rdata(ic_rdata), .ic_rresp(ic_rresp),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_len(dc_req_len),
        .dc_req_ready(dc_req_ready), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
        .dc_rdata(dc_rdata), .dc_rresp(dc_rresp),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy), .rid_err(rid_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: is an AR offer outstanding, is a burst open, who owns it.
    bit          m_pend, m_open, m_owner, m_lg, m_rerr;
    logic [12:0] m_id;
    logic [63:0] m_addr;
    logic [7:0]  m_len;
    int          s_left, ar_wait;

    // Stimulus knobs.
    bit auto_req, rst_req, force_bad;
    int p_req, p_ar, p_rv, p_bad, fixed_delay;

    // Requester side and observation counters.
    bit          rv[2];
    logic [63:0] ra[2];
    logic [7:0]  rl[2];
    logic [7:0]  act_len[2];
    int          bcnt[2], rdy_cnt[2], beat_cnt[2], rlast_cyc[2];
    int          cyc, arv_cycles, rerr_cnt, dc_first;
    logic [12:0] grant_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_pend = 0; m_open = 0; m_owner = 0; m_lg = 1; m_rerr = 0;
        m_id = '0; m_addr = '0; m_len = '0; s_left = 0; ar_wait = 0;
        rv[0] = 0; rv[1] = 0; bcnt[0] = 0; bcnt[1] = 0;
    endtask

    task automatic drive();
        reset = rst_req;
        for (int r = 0; r < 2; r++) begin
            if (!rv[r] && auto_req && $urandom_range(99) < p_req) begin
                rv[r] = 1;
                ra[r] = {$urandom, $urandom};
                rl[r] = 8'($urandom_range(7));
            end else if (rv[r] && auto_req && !(m_pend && m_owner == r[0]) && $urandom_range(99) < 2) begin
                rv[r] = 0;
            end
        end
        ic_req_valid = rv[0]; ic_req_addr = ra[0]; ic_req_len = rl[0];
        dc_req_valid = rv[1]; dc_req_addr = ra[1]; dc_req_len = rl[1];
        if (m_pend) m_axi_arready = (fixed_delay >= 0) ? (ar_wait >= fixed_delay) : ($urandom_range(99) < p_ar);
        else        m_axi_arready = 1'($urandom);
        m_axi_rvalid = 0;
        m_axi_rid    = 13'($urandom);
        m_axi_rdata  = {$urandom, $urandom};
        m_axi_rresp  = 2'($urandom);
        m_axi_rlast  = 1'($urandom);
        if (m_open && force_bad && s_left == 1) begin
            m_axi_rvalid = 1; m_axi_rid = 13'd5; m_axi_rlast = 1; force_bad = 0;
        end else if (m_open && $urandom_range(99) < p_rv) begin
            m_axi_rvalid = 1;
            if ($urandom_range(99) < p_bad) m_axi_rid = 13'd5;
            else begin m_axi_rid = m_id; m_axi_rlast = (s_left == 0); end
        end
    endtask

    task automatic check_req(input int r, input logic rdy, input logic rv_o, input logic rl_o,
                             input logic [63:0] rd, input logic [1:0] rs, input logic good);
        string p;
        logic  mine, e_rdy;
        p     = (r == 0) ? "ic" : "dc";
        mine  = good && (m_owner == r[0]);
        e_rdy = m_pend && m_axi_arready && (m_owner == r[0]);
        chk({p, "_req_ready"}, 64'(rdy), 64'(e_rdy));
        chk({p, "_rvalid"}, 64'(rv_o), 64'(mine));
        chk({p, "_rlast"}, 64'(rl_o), 64'(mine && m_axi_rlast));
        chk({p, "_rdata"}, rd, mine ? m_axi_rdata : 64'd0);
        chk({p, "_rresp"}, 64'(rs), 64'(mine ? m_axi_rresp : 2'b00));
        if (rdy) rdy_cnt[r]++;
        if (e_rdy) begin rv[r] = 0; act_len[r] = rl[r]; end
        if (rv_o) begin
            beat_cnt[r]++; bcnt[r]++;
            if (rl_o) begin
                chk({p, "_burst_beats"}, 64'(bcnt[r]), 64'(act_len[r]) + 64'd1);
                bcnt[r] = 0; rlast_cyc[r] = cyc;
            end
        end
    endtask

    task automatic check_outputs();
        logic good;
        good = m_open && m_axi_rvalid && (m_axi_rid == m_id);
        chk("arvalid", 64'(m_axi_arvalid), 64'(m_pend));
        chk("arid", 64'(m_axi_arid), 64'(m_id));
        chk("araddr", m_axi_araddr, m_addr);
        chk("arlen", 64'(m_axi_arlen), 64'(m_len));
        chk("arsize", 64'(m_axi_arsize), 64'd3);
        chk("arburst", 64'(m_axi_arburst), 64'd2);
        chk("arlock_cache_prot", 64'({m_axi_arlock, m_axi_arcache, m_axi_arprot}), 64'd0);
        chk("rready", 64'(m_axi_rready), 64'(m_open));
        chk("busy", 64'(busy), 64'(m_pend || m_open));
        chk("rid_err", 64'(rid_err), 64'(m_rerr));
        check_req(0, ic_req_ready, ic_rvalid, ic_rlast, ic_rdata, ic_rresp, good);
        check_req(1, dc_req_ready, dc_rvalid, dc_rlast, dc_rdata, dc_rresp, good);
        if (m_axi_arvalid) arv_cycles++;
        if (m_axi_arvalid && m_axi_arready) grant_q.push_back(m_axi_arid);
        if (m_axi_arvalid && m_axi_arid == 13'd1 && dc_first < 0) dc_first = cyc;
        if (rid_err) rerr_cnt++;
    endtask

    // Advance the model by the clock edge about to sample the current inputs.
    task automatic update_model();
        logic good, w;
        good = m_open && m_axi_rvalid && (m_axi_rid == m_id);
        cyc++;
        if (reset) begin
            model_reset();
        end else begin
            m_rerr = m_open && m_axi_rvalid && (m_axi_rid != m_id);
            if (!m_pend && !m_open) begin
                if (ic_req_valid || dc_req_valid) begin
                    w = (ic_req_valid && dc_req_valid) ? !m_lg : dc_req_valid;
                    m_pend = 1; m_owner = w; m_lg = w; ar_wait = 0;
                    m_id   = w ? 13'd1 : 13'd0;
                    m_addr = w ? dc_req_addr : ic_req_addr;
                    m_len  = w ? dc_req_len : ic_req_len;
                end
            end else if (m_pend) begin
                if (m_axi_arready) begin m_pend = 0; m_open = 1; s_left = int'(m_len); end
                else ar_wait++;
            end else if (good) begin
                if (m_axi_rlast) m_open = 0;
                else s_left--;
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        check_outputs();
        update_model();
    endtask

    task automatic run_idle(input int budget);
        int  n;
        bit  done;
        n = 0; done = 0;
        while (!done && n < budget) begin
            step(); n++;
            done = !m_pend && !m_open && !rv[0] && !rv[1];
        end
        chk("run_completes", 64'(done), 64'd1);
    endtask

    task automatic clear_counts();
        for (int r = 0; r < 2; r++) begin rdy_cnt[r] = 0; beat_cnt[r] = 0; rlast_cyc[r] = -1; end
        arv_cycles = 0; rerr_cnt = 0; dc_first = -1;
    endtask

    task automatic set_req(input int r, input logic [63:0] a, input logic [7:0] l);
        rv[r] = 1; ra[r] = a; rl[r] = l;
    endtask

    initial begin
        reset = 1; ic_req_valid = 0; dc_req_valid = 0; ic_req_addr = '0; dc_req_addr = '0;
        ic_req_len = '0; dc_req_len = '0; m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0;
        m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
        ra[0] = '0; ra[1] = '0; rl[0] = '0; rl[1] = '0; act_len[0] = '0; act_len[1] = '0;
        cyc = 0; auto_req = 0; force_bad = 0; p_req = 0; p_ar = 50; p_rv = 80; p_bad = 0; fixed_delay = -1;
        model_reset(); clear_counts();

        // Reset, then a tie on the first cycle after reset: icache, dcache, icache.
        rst_req = 1;
        repeat (3) step();
        rst_req = 0;
        set_req(0, 64'h2000, 8'd3); set_req(1, 64'h3000, 8'd2);
        run_idle(300);
        set_req(0, 64'h2040, 8'd1); set_req(1, 64'h3040, 8'd0);
        run_idle(300);
        chk("tie_grant0", 64'(grant_q.size() > 0 ? grant_q[0] : 13'h1fff), 64'd0);
        chk("tie_grant1", 64'(grant_q.size() > 1 ? grant_q[1] : 13'h1fff), 64'd1);
        chk("tie_grant2", 64'(grant_q.size() > 2 ? grant_q[2] : 13'h1fff), 64'd0);

        // Icache-only burst with arready held off for three cycles.
        clear_counts(); fixed_delay = 3; p_rv = 100;
        set_req(0, 64'h1000, 8'd7);
        run_idle(100);
        chk("a_arvalid_cycles", 64'(arv_cycles), 64'd4);
        chk("a_ic_req_ready_pulses", 64'(rdy_cnt[0]), 64'd1);
        chk("a_ic_beats", 64'(beat_cnt[0]), 64'd8);
        chk("a_dc_beats", 64'(beat_cnt[1]), 64'd0);

        // Dcache request raised during an icache data phase waits for its rlast.
        clear_counts(); fixed_delay = -1; p_rv = 70;
        set_req(0, 64'h4000, 8'd3);
        for (int i = 0; i < 50 && !m_open; i++) step();
        set_req(1, 64'h5000, 8'd1);
        run_idle(200);
        chk("c_dc_ar_gap", 64'(dc_first - rlast_cyc[0]), 64'd2);

        // Unexpected RID (with rlast set) inside an icache burst.
        clear_counts(); p_rv = 100; force_bad = 1;
        set_req(0, 64'h6000, 8'd3);
        run_idle(100);
        chk("d_rid_err_pulses", 64'(rerr_cnt), 64'd1);
        chk("d_ic_beats", 64'(beat_cnt[0]), 64'd4);

        // Reset on beat 3 of 8, then a fresh icache burst.
        clear_counts();
        set_req(0, 64'h7000, 8'd7);
        for (int i = 0; i < 50 && !(m_open && s_left == 5); i++) step();
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        chk("r_busy_after_reset", 64'(busy), 64'd0);
        chk("r_beats_before_reset", 64'(beat_cnt[0]), 64'd3);
        set_req(0, 64'h7100, 8'd2);
        run_idle(100);
        chk("r_beats_total", 64'(beat_cnt[0]), 64'd6);

        // Single-beat dcache burst.
        clear_counts();
        set_req(1, 64'h8000, 8'd0);
        run_idle(100);
        chk("e_dc_beats", 64'(beat_cnt[1]), 64'd1);

        // Randomized soak with occasional resets and bad RIDs.
        clear_counts(); auto_req = 1; p_req = 30; p_ar = 50; p_rv = 70; p_bad = 8;
        for (int i = 0; i < 3000; i++) begin
            rst_req = ($urandom_range(999) < 3);
            step();
        end
        rst_req = 0; auto_req = 0;
        run_idle(500);
        chk("soak_rid_err_seen", 64'(rerr_cnt > 0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
